// File: rtl/key_sched_ctrl.sv
// -----------------------------------------------------------------------------
// key_sched_ctrl
//   Sequencer between the AES round engine and key_expand. It accepts a
//   128-bit cipher key, drives key_expand's start pulse and 4-word key load,
//   waits for expansion to finish, and then serves 128-bit round-key requests
//   by walking key_expand's word select 0..3. It is the only driver of
//   key_expand's control inputs.
//
//   Optional feature: define KEY_REUSE_EN to keep the last successfully
//   expanded key. Re-offering that same key in READY then skips the reload.
//
// Ports
//   clk_i, reset_i              clock, asynchronous active-high reset
//   key_valid_i / key_ready_o   cipher key handshake, key_in_i ([127:96]=word 0)
//   keys_ready_o                round keys 0..ROUND_MAX valid in key_expand
//   rk_req_valid_i / _ready_o   round-key request handshake, rk_req_round_i
//   rk_valid_o / rk_ready_i     response handshake: rk_data_o, rk_round_o,
//                               rk_bad_round_o
//   err_timeout_o               sticky expansion timeout, cleared on key accept
//   ke_start_o, ke_cipher_key_o, ke_r_index_o, ke_round_key_num_o
//                               key_expand controls
//   ke_round_key_i, ke_done_i   key_expand word and completion level
// -----------------------------------------------------------------------------
module key_sched_ctrl #(
  parameter int DONE_TIMEOUT = 64,
  parameter int ROUND_MAX    = 10
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         key_valid_i,
  output logic         key_ready_o,
  input  logic [127:0] key_in_i,
  output logic         keys_ready_o,
  input  logic         rk_req_valid_i,
  output logic         rk_req_ready_o,
  input  logic [3:0]   rk_req_round_i,
  output logic         rk_valid_o,
  input  logic         rk_ready_i,
  output logic [127:0] rk_data_o,
  output logic [3:0]   rk_round_o,
  output logic         rk_bad_round_o,
  output logic         err_timeout_o,
  output logic         ke_start_o,
  output logic [31:0]  ke_cipher_key_o,
  output logic [1:0]   ke_r_index_o,
  output logic [3:0]   ke_round_key_num_o,
  input  logic [31:0]  ke_round_key_i,
  input  logic         ke_done_i
);

  localparam int TW = $clog2(DONE_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_READY = 3'd4,
    S_FETCH = 3'd5,
    S_RESP  = 3'd6
  } state_t;

  state_t          state_q;
  logic [1:0]      cnt_q;
  logic [1:0]      cnt_d;
  logic [TW-1:0]   timer_q;
  logic [TW-1:0]   timer_d;
  logic [127:0]    key_q;
  logic            key_ready_q;
  logic            keys_ready_q;
  logic            rk_req_ready_q;
  logic            rk_valid_q;
  logic [127:0]    rk_data_q;
  logic [3:0]      rk_round_q;
  logic            rk_bad_round_q;
  logic            err_timeout_q;
  logic            ke_start_q;
  logic [31:0]     ke_cipher_key_q;
  logic [1:0]      ke_r_index_q;
  logic [3:0]      ke_round_key_num_q;

  logic key_acc;
  logic req_acc;
  logic done_hit;
  logic timeout_hit;
  logic reuse_hit;

  // Select 32-bit word idx of a 128-bit key, word 0 in the top bits.
  function automatic logic [31:0] key_word(input logic [127:0] k, input logic [1:0] idx);
    logic [31:0] w;
    case (idx)
      2'd0:    w = k[127:96];
      2'd1:    w = k[95:64];
      2'd2:    w = k[63:32];
      2'd3:    w = k[31:0];
      default: w = 32'h0000_0000;
    endcase
    return w;
  endfunction

  assign key_acc = key_valid_i & key_ready_q;
  assign req_acc = rk_req_valid_i & rk_req_ready_q;
  assign cnt_d   = cnt_q + 2'd1;
  assign timer_d = (timer_q == TW'(DONE_TIMEOUT)) ? timer_q : timer_q + TW'(1);

  // done is stale on the first WAIT cycle, before key_expand has reloaded.
  assign done_hit    = (timer_q != TW'(0)) && ke_done_i;
  assign timeout_hit = !done_hit && (timer_q == TW'(DONE_TIMEOUT - 1));

`ifdef KEY_REUSE_EN
  logic [127:0] last_key_q;

  assign reuse_hit = (key_in_i == last_key_q);

  // Remember the last key that expanded successfully; forget it on timeout.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      last_key_q <= 128'h0;
    end else if (state_q == S_WAIT && done_hit) begin
      last_key_q <= key_q;
    end else if (state_q == S_WAIT && timeout_hit) begin
      last_key_q <= 128'h0;
    end else begin
      last_key_q <= last_key_q;
    end
  end
`else
  assign reuse_hit = 1'b0;
`endif

  // Control FSM with registered outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q            <= S_IDLE;
      cnt_q              <= 2'd0;
      timer_q            <= TW'(0);
      key_q              <= 128'h0;
      key_ready_q        <= 1'b1;
      keys_ready_q       <= 1'b0;
      rk_req_ready_q     <= 1'b0;
      rk_valid_q         <= 1'b0;
      rk_data_q          <= 128'h0;
      rk_round_q         <= 4'd0;
      rk_bad_round_q     <= 1'b0;
      err_timeout_q      <= 1'b0;
      ke_start_q         <= 1'b0;
      ke_cipher_key_q    <= 32'h0;
      ke_r_index_q       <= 2'd0;
      ke_round_key_num_q <= 4'd0;
    end else begin
      ke_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (key_acc) begin
            key_q         <= key_in_i;
            err_timeout_q <= 1'b0;
            key_ready_q   <= 1'b0;
            keys_ready_q  <= 1'b0;
            ke_start_q    <= 1'b1;
            state_q       <= S_START;
          end
        end
        S_START: begin
          cnt_q           <= 2'd0;
          ke_cipher_key_q <= key_word(key_q, 2'd0);
          state_q         <= S_LOAD;
        end
        S_LOAD: begin
          if (cnt_q == 2'd3) begin
            cnt_q           <= 2'd0;
            timer_q         <= TW'(0);
            ke_cipher_key_q <= 32'h0;
            state_q         <= S_WAIT;
          end else begin
            cnt_q           <= cnt_d;
            ke_cipher_key_q <= key_word(key_q, cnt_d);
          end
        end
        S_WAIT: begin
          if (done_hit) begin
            keys_ready_q   <= 1'b1;
            key_ready_q    <= 1'b1;
            rk_req_ready_q <= 1'b1;
            state_q        <= S_READY;
          end else if (timeout_hit) begin
            err_timeout_q <= 1'b1;
            keys_ready_q  <= 1'b0;
            key_ready_q   <= 1'b1;
            state_q       <= S_IDLE;
          end else begin
            timer_q <= timer_d;
          end
        end
        S_READY: begin
          // A key offered together with a request wins; the request waits.
          if (key_acc) begin
            if (!reuse_hit) begin
              key_q          <= key_in_i;
              err_timeout_q  <= 1'b0;
              key_ready_q    <= 1'b0;
              rk_req_ready_q <= 1'b0;
              keys_ready_q   <= 1'b0;
              ke_start_q     <= 1'b1;
              state_q        <= S_START;
            end
          end else if (!ke_done_i) begin
            // key_expand was restarted behind our back: its keys are gone.
            keys_ready_q   <= 1'b0;
            rk_req_ready_q <= 1'b0;
            state_q        <= S_IDLE;
          end else if (req_acc) begin
            key_ready_q    <= 1'b0;
            rk_req_ready_q <= 1'b0;
            rk_round_q     <= rk_req_round_i;
            if (rk_req_round_i > 4'(ROUND_MAX)) begin
              rk_data_q      <= 128'h0;
              rk_bad_round_q <= 1'b1;
              rk_valid_q     <= 1'b1;
              state_q        <= S_RESP;
            end else begin
              ke_round_key_num_q <= rk_req_round_i;
              ke_r_index_q       <= 2'd0;
              cnt_q              <= 2'd0;
              state_q            <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          // (3 - cnt) * 32 places word 0 in the top bits.
          rk_data_q[{~cnt_q, 5'd0} +: 32] <= ke_round_key_i;
          if (cnt_q == 2'd3) begin
            cnt_q      <= 2'd0;
            rk_valid_q <= 1'b1;
            state_q    <= S_RESP;
          end else begin
            cnt_q        <= cnt_d;
            ke_r_index_q <= cnt_d;
          end
        end
        S_RESP: begin
          if (rk_ready_i) begin
            rk_valid_q     <= 1'b0;
            rk_bad_round_q <= 1'b0;
            key_ready_q    <= 1'b1;
            rk_req_ready_q <= 1'b1;
            state_q        <= S_READY;
          end
        end
        default: begin
          key_ready_q    <= 1'b1;
          keys_ready_q   <= 1'b0;
          rk_req_ready_q <= 1'b0;
          rk_valid_q     <= 1'b0;
          state_q        <= S_IDLE;
        end
      endcase
    end
  end

  assign key_ready_o        = key_ready_q;
  assign keys_ready_o       = keys_ready_q;
  assign rk_req_ready_o     = rk_req_ready_q;
  assign rk_valid_o         = rk_valid_q;
  assign rk_data_o          = rk_data_q;
  assign rk_round_o         = rk_round_q;
  assign rk_bad_round_o     = rk_bad_round_q;
  assign err_timeout_o      = err_timeout_q;
  assign ke_start_o         = ke_start_q;
  assign ke_cipher_key_o    = ke_cipher_key_q;
  assign ke_r_index_o       = ke_r_index_q;
  assign ke_round_key_num_o = ke_round_key_num_q;

endmodule

// File: tb/tb_key_sched_ctrl.sv
module tb_key_sched_ctrl;

  logic         clk = 1'b0;
  logic         reset;
  logic         key_valid;
  logic         key_ready;
  logic [127:0] key_in;
  logic         keys_ready;
  logic         rk_req_valid;
  logic         rk_req_ready;
  logic [3:0]   rk_req_round;
  logic         rk_valid;
  logic         rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_round;
  logic         rk_bad_round;
  logic         err_timeout;
  logic         ke_start;
  logic [31:0]  ke_cipher_key;
  logic [1:0]   ke_r_index;
  logic [3:0]   ke_round_key_num;
  logic [31:0]  ke_round_key;
  logic         ke_done;

  always #5 clk = ~clk;

  key_sched_ctrl dut (
    .clk_i              (clk),
    .reset_i            (reset),
    .key_valid_i        (key_valid),
    .key_ready_o        (key_ready),
    .key_in_i           (key_in),
    .keys_ready_o       (keys_ready),
    .rk_req_valid_i     (rk_req_valid),
    .rk_req_ready_o     (rk_req_ready),
    .rk_req_round_i     (rk_req_round),
    .rk_valid_o         (rk_valid),
    .rk_ready_i         (rk_ready),
    .rk_data_o          (rk_data),
    .rk_round_o         (rk_round),
    .rk_bad_round_o     (rk_bad_round),
    .err_timeout_o      (err_timeout),
    .ke_start_o         (ke_start),
    .ke_cipher_key_o    (ke_cipher_key),
    .ke_r_index_o       (ke_r_index),
    .ke_round_key_num_o (ke_round_key_num),
    .ke_round_key_i     (ke_round_key),
    .ke_done_i          (ke_done)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural key_expand model ----------------
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    logic [7:0] bb;
    p = 8'h00;
    aa = a;
    bb = b;
    for (int i = 0; i < 8; i++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = {1'b0, bb[7:1]};
    end
    return p;
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h00;
    for (int b = 1; b < 256; b++)
      if (gmul(a, 8'(b)) == 8'h01) inv = 8'(b);
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [1407:0] expand(input logic [127:0] k);
    logic [31:0]   w [0:43];
    logic [31:0]   t;
    logic [7:0]    rc;
    logic [1407:0] r;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])} ^ {rc, 24'h0};
        rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
      end
      w[i] = w[i-4] ^ t;
    end
    for (int i = 0; i < 44; i++) r[(43-i)*32 +: 32] = w[i];
    return r;
  endfunction

  logic [1407:0] ke_mem     = '0;
  logic [31:0]   ld_buf [0:2];
  logic [1:0]    ld_cnt     = 2'd0;
  logic          ld_busy    = 1'b0;
  logic          done_q     = 1'b0;
  logic          never_done = 1'b0;
  logic          kill_done  = 1'b0;

  always @(posedge clk) begin
    if (ke_start) begin
      done_q  <= 1'b0;
      ld_cnt  <= 2'd0;
      ld_busy <= 1'b1;
    end else if (ld_busy) begin
      if (ld_cnt == 2'd3) begin
        ke_mem  <= expand({ld_buf[0], ld_buf[1], ld_buf[2], ke_cipher_key});
        done_q  <= !never_done;
        ld_busy <= 1'b0;
      end else begin
        ld_buf[ld_cnt] <= ke_cipher_key;
        ld_cnt         <= ld_cnt + 2'd1;
      end
    end
  end

  always_comb begin
    int idx;
    idx = int'(ke_round_key_num) * 4 + int'(ke_r_index);
    ke_round_key = 32'h0;
    if (idx <= 43) ke_round_key = ke_mem[(43-idx)*32 +: 32];
  end

  assign ke_done = done_q & ~kill_done;

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [3:0]   rnd;
    logic [127:0] data;
    logic         bad;
    int           lat;
    logic         hold;
  } exp_t;
  exp_t sb[$];

  localparam logic [127:0] K1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K2 = 128'h000102030405060708090a0b0c0d0e0f;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k, input bit expect_done);
    int n;
    key_in = k;
    key_valid = 1'b1;
    n = 0;
    while (!key_ready && n < 200) begin tick; n++; end
    check_eq("key_ready_wait", 128'(key_ready), 128'd1);
    tick;
    key_valid = 1'b0;
    check_eq("start_pulse", 128'(ke_start), 128'd1);
    check_eq("start_key_ready", 128'(key_ready), 128'd0);
    check_eq("start_rk_req_ready", 128'(rk_req_ready), 128'd0);
    check_eq("start_keys_ready", 128'(keys_ready), 128'd0);
    check_eq("start_err_clear", 128'(err_timeout), 128'd0);
    for (int i = 0; i < 4; i++) begin
      tick;
      check_eq("start_one_cycle", 128'(ke_start), 128'd0);
      check_eq("load_word", 128'(ke_cipher_key), 128'(k[127-32*i -: 32]));
    end
    if (expect_done) begin
      n = 0;
      while (!keys_ready && n < 200) begin tick; n++; end
      check_eq("keys_ready", 128'(keys_ready), 128'd1);
      check_eq("ready_rk_req_ready", 128'(rk_req_ready), 128'd1);
    end
  endtask

  task automatic request(input logic [3:0] rnd, input logic [127:0] data, input logic bad, input logic hold);
    int   n;
    exp_t e;
    rk_req_round = rnd;
    rk_req_valid = 1'b1;
    n = 0;
    while (!rk_req_ready && n < 200) begin tick; n++; end
    check_eq("req_ready_wait", 128'(rk_req_ready), 128'd1);
    tick;
    rk_req_valid = 1'b0;
    e.rnd = rnd;
    e.data = data;
    e.bad = bad;
    e.lat = bad ? 0 : 4;
    e.hold = hold;
    sb.push_back(e);
  endtask

  task automatic wait_resp;
    int   n;
    exp_t e;
    e = sb.pop_front();
    n = 0;
    while (!rk_valid && n < 20) begin tick; n++; end
    check_eq("rk_valid", 128'(rk_valid), 128'd1);
    check_eq("rk_latency", 128'(n), 128'(e.lat));
    check_eq("rk_data", rk_data, e.data);
    check_eq("rk_round", 128'(rk_round), 128'(e.rnd));
    check_eq("rk_bad_round", 128'(rk_bad_round), 128'(e.bad));
    if (e.hold) begin
      for (int i = 0; i < 3; i++) begin
        tick;
        check_eq("hold_valid", 128'(rk_valid), 128'd1);
        check_eq("hold_data", rk_data, e.data);
        check_eq("hold_bad", 128'(rk_bad_round), 128'(e.bad));
        check_eq("hold_req_ready", 128'(rk_req_ready), 128'd0);
      end
    end
    rk_ready = 1'b1;
    tick;
    rk_ready = 1'b0;
    check_eq("resp_done_valid", 128'(rk_valid), 128'd0);
    check_eq("resp_done_bad", 128'(rk_bad_round), 128'd0);
    check_eq("resp_done_req_ready", 128'(rk_req_ready), 128'd1);
  endtask

  initial begin
    reset = 1'b1;
    key_valid = 1'b0;
    key_in = 128'h0;
    rk_req_valid = 1'b0;
    rk_req_round = 4'd0;
    rk_ready = 1'b0;
    tick;
    tick;
    check_eq("rst_key_ready", 128'(key_ready), 128'd1);
    check_eq("rst_keys_ready", 128'(keys_ready), 128'd0);
    check_eq("rst_rk_valid", 128'(rk_valid), 128'd0);
    check_eq("rst_rk_data", rk_data, 128'h0);
    check_eq("rst_ke_start", 128'(ke_start), 128'd0);
    check_eq("rst_err", 128'(err_timeout), 128'd0);
    reset = 1'b0;
    tick;

    // Reset in the middle of the key load.
    key_in = K1;
    key_valid = 1'b1;
    tick;
    key_valid = 1'b0;
    tick;
    tick;
    #1 reset = 1'b1;
    #1;
    check_eq("midload_key_ready", 128'(key_ready), 128'd1);
    check_eq("midload_cipher_key", 128'(ke_cipher_key), 128'd0);
    check_eq("midload_ke_start", 128'(ke_start), 128'd0);
    check_eq("midload_keys_ready", 128'(keys_ready), 128'd0);
    reset = 1'b0;
    tick;

    // Full load and FIPS-197 round keys.
    load_key(K1, 1'b1);
    request(4'd0, K1, 1'b0, 1'b0);
    wait_resp();
    request(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0, 1'b0);
    wait_resp();
    request(4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6, 1'b0, 1'b0);
    wait_resp();
    request(4'd11, 128'h0, 1'b1, 1'b1);
    wait_resp();
    request(4'd15, 128'h0, 1'b1, 1'b0);
    wait_resp();

    // Key and request together: key wins, request stays pending.
    rk_req_round = 4'd1;
    rk_req_valid = 1'b1;
    load_key(K2, 1'b1);
    request(4'd1, ke_mem[(40-4*1)*32 +: 128], 1'b0, 1'b0);
    wait_resp();
    request(4'd7, ke_mem[(40-4*7)*32 +: 128], 1'b0, 1'b0);
    wait_resp();

    // External restart of key_expand while READY.
    kill_done = 1'b1;
    tick;
    check_eq("restart_keys_ready", 128'(keys_ready), 128'd0);
    check_eq("restart_key_ready", 128'(key_ready), 128'd1);
    check_eq("restart_req_ready", 128'(rk_req_ready), 128'd0);
    kill_done = 1'b0;
    load_key(K1, 1'b1);

`ifdef KEY_REUSE_EN
    key_in = K1;
    key_valid = 1'b1;
    tick;
    key_valid = 1'b0;
    check_eq("reuse_no_start", 128'(ke_start), 128'd0);
    check_eq("reuse_keys_ready", 128'(keys_ready), 128'd1);
    check_eq("reuse_key_ready", 128'(key_ready), 128'd1);
    load_key(K2, 1'b1);
`else
    load_key(K1, 1'b1);
`endif
    request(4'd10, ke_mem[0 +: 128], 1'b0, 1'b0);
    wait_resp();

    // key_expand never finishes: timeout after 64 WAIT cycles.
    never_done = 1'b1;
    load_key(K2, 1'b0);
    repeat (64) tick;
    check_eq("wait64_err", 128'(err_timeout), 128'd0);
    check_eq("wait64_key_ready", 128'(key_ready), 128'd0);
    tick;
    check_eq("timeout_err", 128'(err_timeout), 128'd1);
    check_eq("timeout_keys_ready", 128'(keys_ready), 128'd0);
    check_eq("timeout_key_ready", 128'(key_ready), 128'd1);
    never_done = 1'b0;
    load_key(K1, 1'b1);
    request(4'd1, 128'ha0fafe1788542cb123a339392a6c7605, 1'b0, 1'b0);
    wait_resp();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
